ring_slot_arbiter: RTL and testbench

Round-robin arbiter that shares one timing resource (a ring-counter strobe chain or similar datapath slot) among C_NUM_REQ requesters. A one-hot rotating priority pointer decides the winner. Grants are registered, held while the winner keeps requesting, and forcibly revoked after C_MAX_HOLD cycles. A one-cycle break-before-make gap separates any two grants. The block sits between the requesting engines and the shared ring-counter/strobe logic and drives its enables.

---
 rtl/ring_slot_arbiter_pkg.sv | 19 +
 rtl/ring_slot_arbiter_if.sv | 40 ++++
 rtl/ring_slot_arbiter_prio_pick.sv | 33 +++
 rtl/ring_slot_arbiter.sv | 119 +++++++++++
 tb/tb_ring_slot_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ring_slot_arbiter_pkg.sv
// ring_arb_pkg: shared types and helpers for the ring slot arbiter.
//   arb_state_e      : arbiter FSM states (IDLE, GRANT, GAP)
//   hold_cnt_width() : width of a hold counter that reaches max_hold
//                      without wrapping
package ring_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // The counter must represent max_hold itself, so the width covers
  // max_hold + 1 distinct values (0..max_hold).
  function automatic int hold_cnt_width(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/ring_slot_arbiter_if.sv
// ring_slot_arbiter_if: request/grant bundle between the requesting
// engines (master) and the arbiter (slave).
//   REQ     : per-requester request level
//   GNT     : registered one-hot grant, or all-zero
//   BUSY    : any GNT bit high
//   PTR     : one-hot priority pointer
//   PREEMPT : one-cycle pulse after a hold-limit revocation
//
// Handshake: REQ[i] is a level, not a pulse. A requester raises REQ[i]
// and keeps it high; it owns the resource on every cycle GNT[i] is high.
// Dropping REQ[i] while granted releases the resource (GNT falls after
// the next edge). GNT is never high for a requester whose REQ was low
// at the edge that produced it, and at most one GNT bit is ever high.
interface ring_slot_arbiter_if #(
  parameter int C_NUM_REQ = 4
) ();

  logic [C_NUM_REQ-1:0] REQ;
  logic [C_NUM_REQ-1:0] GNT;
  logic                 BUSY;
  logic [C_NUM_REQ-1:0] PTR;
  logic                 PREEMPT;

  modport master (
    output REQ,
    input  GNT,
    input  BUSY,
    input  PTR,
    input  PREEMPT
  );

  modport slave (
    input  REQ,
    output GNT,
    output BUSY,
    output PTR,
    output PREEMPT
  );

endinterface

// File: rtl/ring_slot_arbiter_prio_pick.sv
// ring_prio_pick: combinational rotating-priority selector.
//   req_i   : request vector
//   ptr_i   : one-hot pointer; its bit has the highest priority, and
//             priority decreases upward with wrap-around
//   win_o   : one-hot winner (zero when no request)
//   valid_o : at least one request present
module ring_prio_pick #(
  parameter int C_NUM_REQ = 4
) (
  input  logic [C_NUM_REQ-1:0] req_i,
  input  logic [C_NUM_REQ-1:0] ptr_i,
  output logic [C_NUM_REQ-1:0] win_o,
  output logic                 valid_o
);

  logic [2*C_NUM_REQ-1:0] dbl_req;
  logic [2*C_NUM_REQ-1:0] dbl_ptr;
  logic [2*C_NUM_REQ-1:0] dbl_win;

  // Duplicating the request vector lays the wrapped-around requesters
  // above the pointer position. Subtracting the pointer borrows through
  // the zero bits from the pointer upward and clears the first set bit
  // at or above it; masking against the original isolates exactly that
  // bit. Bits below the pointer never see a borrow and drop out.
  assign dbl_req = {req_i, req_i};
  assign dbl_ptr = {{C_NUM_REQ{1'b0}}, ptr_i};
  assign dbl_win = dbl_req & ~(dbl_req - dbl_ptr);

  // Fold the upper copy back onto the requester indices.
  assign win_o   = dbl_win[C_NUM_REQ-1:0] | dbl_win[2*C_NUM_REQ-1:C_NUM_REQ];
  assign valid_o = |req_i;

endmodule

// File: rtl/ring_slot_arbiter.sv
// ring_slot_arbiter: round-robin owner of one shared timing slot.
//   CK    : clock, rising edge
//   RST   : asynchronous active-high reset
//   bus   : slave side of ring_slot_arbiter_if (REQ in; GNT, BUSY, PTR,
//           PREEMPT out, all straight from flops)
//   STATE : current FSM state, for observation
// A grant lasts while the winner keeps REQ high, up to C_MAX_HOLD
// cycles, and is always followed by exactly one GAP cycle with GNT=0.
module ring_slot_arbiter
  import ring_arb_pkg::*;
#(
  parameter int C_NUM_REQ  = 4,
  parameter int C_MAX_HOLD = 8
) (
  input  logic                 CK,
  input  logic                 RST,
  ring_slot_arbiter_if.slave   bus,
  output arb_state_e           STATE
);

  localparam int HW = hold_cnt_width(C_MAX_HOLD);

  arb_state_e           state_q, state_d;
  logic [C_NUM_REQ-1:0] gnt_q, gnt_d;
  logic [C_NUM_REQ-1:0] ptr_q, ptr_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 busy_q, busy_d;
  logic                 preempt_q, preempt_d;

  logic [C_NUM_REQ-1:0] win;
  logic                 win_valid;
  logic [C_NUM_REQ-1:0] ptr_after_gnt;
  logic                 holder_req;

  ring_prio_pick #(
    .C_NUM_REQ (C_NUM_REQ)
  ) u_pick (
    .req_i   (bus.REQ),
    .ptr_i   (ptr_q),
    .win_o   (win),
    .valid_o (win_valid)
  );

  // Next pointer is one position past the current holder, so rotating
  // the one-hot grant left by one gives it directly.
  assign ptr_after_gnt = {gnt_q[C_NUM_REQ-2:0], gnt_q[C_NUM_REQ-1]};
  assign holder_req    = |(bus.REQ & gnt_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    case (state_q)
      IDLE, GAP: begin
        if (win_valid) begin
          state_d = GRANT;
          gnt_d   = win;
          hold_d  = HW'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end

      GRANT: begin
        if (!holder_req) begin
          state_d = GAP;
          gnt_d   = '0;
          ptr_d   = ptr_after_gnt;
          hold_d  = '0;
        end else if (hold_q == HW'(C_MAX_HOLD)) begin
          state_d   = GAP;
          gnt_d     = '0;
          ptr_d     = ptr_after_gnt;
          hold_d    = '0;
          preempt_d = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase

    busy_d = |gnt_d;
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= {{(C_NUM_REQ-1){1'b0}}, 1'b1};
      hold_q    <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.BUSY    = busy_q;
  assign bus.PTR     = ptr_q;
  assign bus.PREEMPT = preempt_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_ring_slot_arbiter.sv
// Bench for ring_slot_arbiter: three instances (hold limits 8, 2, 1)
// run side by side, each checked every cycle against an index-based
// behavioural model, plus hand-computed literal expectations.
module tb_ring_slot_arbiter;
  import ring_arb_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic CK  = 1'b0;
  logic RST = 1'b0;
  always #5 CK = ~CK;

  ring_slot_arbiter_if #(.C_NUM_REQ(N)) ifa ();
  ring_slot_arbiter_if #(.C_NUM_REQ(N)) ifb ();
  ring_slot_arbiter_if #(.C_NUM_REQ(N)) ifc ();
  arb_state_e st_a, st_b, st_c;

  ring_slot_arbiter #(.C_NUM_REQ(N), .C_MAX_HOLD(8)) u_a (
    .CK(CK), .RST(RST), .bus(ifa), .STATE(st_a));
  ring_slot_arbiter #(.C_NUM_REQ(N), .C_MAX_HOLD(2)) u_b (
    .CK(CK), .RST(RST), .bus(ifb), .STATE(st_b));
  ring_slot_arbiter #(.C_NUM_REQ(N), .C_MAX_HOLD(1)) u_c (
    .CK(CK), .RST(RST), .bus(ifc), .STATE(st_c));

  int n_checks = 0;
  int n_errors = 0;
  bit seen_rst = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // holder index (-1: none), tenure length, pointer index, gap flag
  int m_h[3];
  int m_ten[3];
  int m_ptr[3];
  bit m_gap[3];
  bit m_pre[3];
  int max_hold[3] = '{8, 2, 1};

  function automatic logic [N-1:0] req_of(input int k);
    case (k)
      0:       return ifa.REQ;
      1:       return ifb.REQ;
      default: return ifc.REQ;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_h[k] = -1; m_ten[k] = 0; m_ptr[k] = 0; m_gap[k] = 1'b0; m_pre[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    logic [N-1:0] r;
    r = req_of(k);
    m_pre[k] = 1'b0;
    if (m_h[k] >= 0) begin
      if (!r[m_h[k]]) begin
        m_ptr[k] = (m_h[k] + 1) % N; m_h[k] = -1; m_gap[k] = 1'b1;
      end else if (m_ten[k] == max_hold[k]) begin
        m_ptr[k] = (m_h[k] + 1) % N; m_h[k] = -1; m_gap[k] = 1'b1; m_pre[k] = 1'b1;
      end else begin
        m_ten[k]++;
      end
    end else begin
      m_gap[k] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_h[k] < 0 && r[(m_ptr[k] + i) % N]) begin
          m_h[k] = (m_ptr[k] + i) % N;
          m_ten[k] = 1;
        end
      end
    end
  endtask

  initial model_reset();

  always @(posedge CK or posedge RST) begin
    if (RST) model_reset();
    else for (int k = 0; k < 3; k++) model_step(k);
  end

  function automatic logic [31:0] model_out(input int k, input int f);
    case (f)
      0: return (m_h[k] >= 0) ? (32'd1 << m_h[k]) : 32'd0;
      1: return (m_h[k] >= 0) ? 32'd1 : 32'd0;
      2: return 32'd1 << m_ptr[k];
      3: return {31'd0, m_pre[k]};
      default: return (m_h[k] >= 0) ? 32'(GRANT) : (m_gap[k] ? 32'(GAP) : 32'(IDLE));
    endcase
  endfunction

  function automatic logic [31:0] dut_out(input int k, input int f);
    logic [N-1:0] g, p;
    logic b, pr;
    arb_state_e s;
    case (k)
      0:       begin g = ifa.GNT; b = ifa.BUSY; p = ifa.PTR; pr = ifa.PREEMPT; s = st_a; end
      1:       begin g = ifb.GNT; b = ifb.BUSY; p = ifb.PTR; pr = ifb.PREEMPT; s = st_b; end
      default: begin g = ifc.GNT; b = ifc.BUSY; p = ifc.PTR; pr = ifc.PREEMPT; s = st_c; end
    endcase
    case (f)
      0: return 32'(g);
      1: return 32'(b);
      2: return 32'(p);
      3: return 32'(pr);
      default: return 32'(s);
    endcase
  endfunction

  string inst_name[3] = '{"A", "B", "C"};
  string fld_name[5]  = '{"GNT", "BUSY", "PTR", "PREEMPT", "STATE"};

  // ---------------- scoreboard (grant order on B, REQ=1111) ----------------
  logic [N-1:0] exp_q[$] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] prev_gnt_b = '0;
  int           preempt_cnt_b = 0;

  always @(negedge CK) begin
    if (RST) begin
      prev_gnt_b = '0;
    end else if (seen_rst) begin
      for (int k = 0; k < 3; k++)
        for (int f = 0; f < 5; f++)
          chk($sformatf("model_%s_%s", inst_name[k], fld_name[f]), dut_out(k, f), model_out(k, f));
      if (ifb.GNT != '0 && prev_gnt_b == '0) begin
        if (exp_q.size() == 0) chk("order_extra", 32'(ifb.GNT), 32'd0);
        else                   chk("order_B", 32'(ifb.GNT), 32'(exp_q.pop_front()));
      end
      if (ifb.PREEMPT) preempt_cnt_b++;
      prev_gnt_b = ifb.GNT;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge CK);
    #2;
  endtask

  initial begin
    ifa.REQ = '0; ifb.REQ = '0; ifc.REQ = '0;
    #1 RST = 1'b1;
    #7;
    chk("rst_GNT", 32'(ifa.GNT), 32'h0);
    chk("rst_BUSY", 32'(ifa.BUSY), 32'h0);
    chk("rst_PTR", 32'(ifa.PTR), 32'h1);
    chk("rst_PREEMPT", 32'(ifa.PREEMPT), 32'h0);
    chk("rst_STATE", 32'(st_a), 32'(IDLE));
    #4 RST = 1'b0;
    seen_rst = 1'b1;

    tick();
    ifa.REQ = 4'b0100; ifb.REQ = 4'b1111; ifc.REQ = 4'b0001;
    tick(); // E1
    chk("single_first_GNT", 32'(ifa.GNT), 32'h4);
    chk("fair_first_GNT", 32'(ifb.GNT), 32'h1);
    chk("hold1_first_GNT", 32'(ifc.GNT), 32'h1);
    tick(); // E2
    chk("hold1_gap_GNT", 32'(ifc.GNT), 32'h0);
    chk("hold1_PREEMPT", 32'(ifc.PREEMPT), 32'h1);
    chk("hold1_PTR", 32'(ifc.PTR), 32'h2);
    tick(); // E3
    chk("single_third_GNT", 32'(ifa.GNT), 32'h4);
    chk("fair_gap_GNT", 32'(ifb.GNT), 32'h0);
    chk("fair_PREEMPT", 32'(ifb.PREEMPT), 32'h1);
    chk("fair_PTR", 32'(ifb.PTR), 32'h2);
    chk("hold1_regrant_GNT", 32'(ifc.GNT), 32'h1);
    chk("hold1_PREEMPT_clear", 32'(ifc.PREEMPT), 32'h0);
    ifa.REQ = 4'b0000;
    tick(); // E4
    chk("single_rel_GNT", 32'(ifa.GNT), 32'h0);
    chk("single_rel_STATE", 32'(st_a), 32'(GAP));
    chk("single_rel_PTR", 32'(ifa.PTR), 32'h8);
    chk("fair_second_GNT", 32'(ifb.GNT), 32'h2);
    tick(); // E5
    chk("single_idle_STATE", 32'(st_a), 32'(IDLE));
    chk("single_idle_PTR", 32'(ifa.PTR), 32'h8);
    ifa.REQ = 4'b0011;
    tick(); // E6
    chk("wrap_GNT", 32'(ifa.GNT), 32'h1);
    tick(); // E7
    chk("wrap_hold_GNT", 32'(ifa.GNT), 32'h1);
    ifa.REQ = 4'b0010;
    tick(); // E8
    chk("handover_gap_GNT", 32'(ifa.GNT), 32'h0);
    chk("handover_gap_STATE", 32'(st_a), 32'(GAP));
    chk("wrap_after_PTR", 32'(ifa.PTR), 32'h2);
    tick(); // E9
    chk("handover_GNT", 32'(ifa.GNT), 32'h2);
    ifa.REQ = 4'b0000;
    tick(); // E10
    chk("handover_rel_PTR", 32'(ifa.PTR), 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick(); // E11..E13
      chk("idle_STATE", 32'(st_a), 32'(IDLE));
      chk("idle_PTR", 32'(ifa.PTR), 32'h4);
    end
    ifa.REQ = 4'b0100;
    tick(); // E14
    chk("pre_rst_GNT", 32'(ifa.GNT), 32'h4);
    chk("pre_rst_BUSY", 32'(ifa.BUSY), 32'h1);
    #1 RST = 1'b1;
    #1;
    chk("async_rst_GNT_A", 32'(ifa.GNT), 32'h0);
    chk("async_rst_BUSY_A", 32'(ifa.BUSY), 32'h0);
    chk("async_rst_GNT_B", 32'(ifb.GNT), 32'h0);
    ifa.REQ = '0; ifb.REQ = '0; ifc.REQ = '0;
    tick();
    RST = 1'b0;
    #1;
    chk("post_rst_PTR", 32'(ifa.PTR), 32'h1);
    chk("post_rst_STATE", 32'(st_a), 32'(IDLE));
    chk("post_rst_GNT", 32'(ifa.GNT), 32'h0);
    tick();
    tick();
    chk("order_all_seen", 32'(exp_q.size()), 32'd0);
    chk("fair_preempt_count", 32'(preempt_cnt_b), 32'd4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
